// File: rtl/multiciclo_core.sv
// multiciclo_core: multicycle MIPS-subset core with a unified request/ready memory port
module multiciclo_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted,
   output logic [3:0]        state_out
);
   typedef enum logic [3:0] {
      INIT    = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  EXEC_R = 4'd3,
      WB_R    = 4'd4,  EXEC_I = 4'd5,  WB_I   = 4'd6,  MEMADDR = 4'd7,
      MEM_RD  = 4'd8,  WB_MEM = 4'd9,  MEM_WR = 4'd10, BRANCH = 4'd11,
      JUMP    = 4'd12, HALT   = 4'd13
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_SLT   = 6'h2A;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
   logic [31:0] rf_q [32];
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_sx, r_res, addr_full;
   logic        r_ok;

   assign op     = ir_q[31:26];
   assign rs     = ir_q[25:21];
   assign rt     = ir_q[20:16];
   assign rd     = ir_q[15:11];
   assign funct  = ir_q[5:0];
   assign imm_sx = {{16{ir_q[15]}}, ir_q[15:0]};

   // R-type ALU result and whether the funct field is one we execute
   always_comb begin
      r_ok  = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
      r_res = funct == F_ADD ? a_q + b_q :
              funct == F_SUB ? a_q - b_q :
              funct == F_AND ? a_q & b_q :
              funct == F_OR  ? a_q | b_q :
              {31'd0, $signed(a_q) < $signed(b_q)};
   end

   // next-state and datapath register updates for each FSM state
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      alu_d   = alu_q;
      mdr_d   = mdr_q;
      rf_we   = 1'b0;
      rf_wa   = rt;
      rf_wd   = alu_q;
      case (state_q)
         INIT:    state_d = FETCH;
         FETCH:   if (mem_ready) begin
            ir_d    = mem_rdata;
            pc_d    = pc_q + 32'd4;
            state_d = DECODE;
         end
         DECODE: begin
            a_d     = rf_q[rs];
            b_d     = rf_q[rt];
            alu_d   = pc_q + (imm_sx << 2);
            state_d = (op == OP_R && r_ok)         ? EXEC_R  :
                      op == OP_ADDI                ? EXEC_I  :
                      (op == OP_LW || op == OP_SW) ? MEMADDR :
                      op == OP_BEQ                 ? BRANCH  :
                      op == OP_J                   ? JUMP    : HALT;
         end
         EXEC_R: begin
            alu_d   = r_res;
            state_d = WB_R;
         end
         WB_R: begin
            rf_we   = 1'b1;
            rf_wa   = rd;
            state_d = FETCH;
         end
         EXEC_I: begin
            alu_d   = a_q + imm_sx;
            state_d = WB_I;
         end
         WB_I: begin
            rf_we   = 1'b1;
            state_d = FETCH;
         end
         MEMADDR: begin
            alu_d   = a_q + imm_sx;
            state_d = op == OP_LW ? MEM_RD : MEM_WR;
         end
         MEM_RD:  if (mem_ready) begin
            mdr_d   = mem_rdata;
            state_d = WB_MEM;
         end
         WB_MEM: begin
            rf_we   = 1'b1;
            rf_wd   = mdr_q;
            state_d = FETCH;
         end
         MEM_WR:  if (mem_ready) state_d = FETCH;
         BRANCH: begin
            if (a_q == b_q) pc_d = alu_q;
            state_d = FETCH;
         end
         JUMP: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            state_d = FETCH;
         end
         default: state_d = HALT;
      endcase
   end

   // memory port driven straight from registered state so it drops with async reset
   always_comb begin
      mem_req   = state_q inside {FETCH, MEM_RD, MEM_WR};
      mem_we    = state_q == MEM_WR;
      addr_full = state_q == FETCH ? pc_q : mem_req ? alu_q : 32'd0;
      mem_addr  = {addr_full[ADDR_W-1:2], 2'b00};
      mem_wdata = mem_we ? b_q : 32'd0;
   end

   // state, datapath registers and register file; $0 is never written so it stays 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= INIT;
         pc_q    <= RESET_PC;
         ir_q    <= 32'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         alu_q   <= 32'd0;
         mdr_q   <= 32'd0;
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         alu_q   <= alu_d;
         mdr_q   <= mdr_d;
         if (rf_we && rf_wa != 5'd0) rf_q[rf_wa] <= rf_wd;
      end
   end

   assign pc_out    = pc_q[ADDR_W-1:0];
   assign halted    = state_q == HALT;
   assign state_out = state_q;
endmodule

// File: tb/tb_multiciclo_core.sv
// tb_multiciclo_core: ISA-level reference model checking every memory transaction, cycle counts and halt behaviour
module tb_multiciclo_core;
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   logic        clk, reset, mem_req, mem_we, mem_ready, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
   logic [3:0]  state_out;
   logic [31:0] mem [1024];
   logic [31:0] mm  [1024];
   txn_t        exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          mcyc, dcyc, dwait;
   logic [31:0] mpc;

   multiciclo_core #(.RESET_PC(32'h40), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .pc_out(pc_out), .halted(halted), .state_out(state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[11:2]];

   always @(posedge clk)
      if (reset && mem_req && mem_we && mem_ready) mem[mem_addr[11:2]] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [31:0] rtype(input int s, input int t, input int d, input logic [5:0] f);
      return {6'h00, s[4:0], t[4:0], d[4:0], 5'd0, f};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] o, input int s, input int t, input logic [15:0] imm);
      return {o, s[4:0], t[4:0], imm};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) begin
         mem[i] = 32'd0;
         mm[i]  = 32'd0;
      end
   endtask

   task automatic put(input logic [31:0] addr, input logic [31:0] w);
      mem[addr[11:2]] = w;
      mm[addr[11:2]]  = w;
   endtask

   // instruction-at-a-time interpreter: builds the expected access list and zero-wait cycle total
   task automatic model_run(output int cyc, output logic [31:0] pc);
      logic [31:0] r [32];
      logic [31:0] ir, s, a, b, v;
      txn_t        t;
      logic        bad;
      for (int i = 0; i < 32; i++) r[i] = 32'd0;
      pc = 32'h40;
      cyc = 0;
      exp_q.delete();
      for (int k = 0; k < 2000; k++) begin
         ir = mm[pc[11:2]];
         t.we = 1'b0; t.addr = pc; t.data = 32'd0;
         exp_q.push_back(t);
         pc = pc + 32'd4;
         s = {{16{ir[15]}}, ir[15:0]};
         a = r[ir[25:21]];
         b = r[ir[20:16]];
         bad = 1'b0;
         case (ir[31:26])
            6'h00: begin
               case (ir[5:0])
                  6'h20: v = a + b;
                  6'h22: v = a - b;
                  6'h24: v = a & b;
                  6'h25: v = a | b;
                  6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  default: begin v = 32'd0; bad = 1'b1; end
               endcase
               if (!bad && ir[15:11] != 5'd0) r[ir[15:11]] = v;
               if (!bad) cyc += 4;
            end
            6'h08: begin
               if (ir[20:16] != 5'd0) r[ir[20:16]] = a + s;
               cyc += 4;
            end
            6'h23: begin
               t.we = 1'b0; t.addr = a + s; t.data = 32'd0;
               exp_q.push_back(t);
               if (ir[20:16] != 5'd0) r[ir[20:16]] = mm[t.addr[11:2]];
               cyc += 5;
            end
            6'h2B: begin
               t.we = 1'b1; t.addr = a + s; t.data = b;
               exp_q.push_back(t);
               mm[t.addr[11:2]] = b;
               cyc += 4;
            end
            6'h04: begin
               if (a == b) pc = pc + (s << 2);
               cyc += 3;
            end
            6'h02: begin
               pc = {pc[31:28], ir[25:0], 2'b00};
               cyc += 3;
            end
            default: bad = 1'b1;
         endcase
         if (bad) begin
            cyc += 2;
            return;
         end
      end
   endtask

   // hold reset, check idle outputs, release and check the first fetch one cycle later
   task automatic do_reset();
      reset = 1'b0;
      mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_state", {28'd0, state_out}, 32'd0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_pc", pc_out, 32'h40);
      reset = 1'b1;
      @(negedge clk);
      chk("first_req", {31'd0, mem_req}, 32'd1);
      chk("first_addr", mem_addr, 32'h40);
      chk("first_we", {31'd0, mem_we}, 32'd0);
   endtask

   // mode 0: ready always 1; mode 1: random ready; mode 2: every write stalled 3 cycles
   task automatic run_prog(input int mode, input int exp_cyc, input logic [31:0] exp_pc,
                           output int cyc, output int waits);
      int          wcnt = 0;
      logic        pend = 1'b0;
      logic [31:0] pa = 32'd0, pw = 32'd0;
      logic        pwe = 1'b0;
      txn_t        t;
      cyc = 0;
      waits = 0;
      for (int n = 0; n < 5000 && !halted; n++) begin
         mem_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 2) != 0) : !(mem_we && wcnt < 3);
         if (pend) begin
            chk("hold_req", {31'd0, mem_req}, 32'd1);
            chk("hold_addr", mem_addr, pa);
            chk("hold_we", {31'd0, mem_we}, {31'd0, pwe});
            chk("hold_wdata", mem_wdata, pw);
         end
         if (mem_req && mem_ready) begin
            if (exp_q.size() == 0) chk("extra_req", mem_addr, 32'hFFFF_FFFF);
            else begin
               t = exp_q.pop_front();
               chk("req_we", {31'd0, mem_we}, {31'd0, t.we});
               chk("req_addr", mem_addr, t.addr);
               if (t.we) chk("req_wdata", mem_wdata, t.data);
            end
            wcnt = 0;
            pend = 1'b0;
         end else if (mem_req) begin
            waits++;
            wcnt++;
            pend = 1'b1;
            pa = mem_addr;
            pw = mem_wdata;
            pwe = mem_we;
         end
         cyc++;
         @(negedge clk);
      end
      chk("halted", {31'd0, halted}, 32'd1);
      chk("cycles", cyc, exp_cyc + waits);
      chk("txn_left", exp_q.size(), 32'd0);
      chk("halt_pc", pc_out, exp_pc);
      for (int n = 0; n < 6; n++) begin
         mem_ready = 1'b1;
         @(negedge clk);
         chk("halt_noreq", {31'd0, mem_req}, 32'd0);
         chk("halt_state", {28'd0, state_out}, 32'd13);
      end
   endtask

   task automatic load_directed();
      clear_mem();
      put(32'h40, itype(6'h08, 0, 1, 16'd5));
      put(32'h44, itype(6'h08, 0, 2, 16'hFFFD));
      put(32'h48, rtype(1, 2, 3, 6'h20));
      put(32'h4C, rtype(2, 1, 4, 6'h2A));
      put(32'h50, itype(6'h2B, 0, 3, 16'h8));
      put(32'h54, itype(6'h23, 0, 5, 16'h8));
      put(32'h58, itype(6'h2B, 0, 5, 16'hC));
      put(32'h5C, itype(6'h2B, 0, 4, 16'h10));
      put(32'h60, itype(6'h04, 1, 1, 16'd2));
      put(32'h64, 32'hFC00_0000);
      put(32'h68, 32'hFC00_0000);
      put(32'h6C, {6'h02, 26'h100});
      put(32'h400, itype(6'h2B, 0, 5, 16'h20));
      put(32'h404, 32'hFC00_0000);
   endtask

   // forward-only control flow so every random program reaches the trailing halts
   task automatic load_random(input int len);
      logic [31:0] addr;
      logic [5:0]  fl [5];
      fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25; fl[4] = 6'h2A;
      clear_mem();
      for (int i = 512; i < 576; i++) begin
         mem[i] = $urandom;
         mm[i]  = mem[i];
      end
      for (int p = 0; p < len; p++) begin
         addr = 32'h40 + 32'(4 * p);
         case ($urandom_range(0, 7))
            0, 1: put(addr, rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                  fl[$urandom_range(0, 4)]));
            3:    put(addr, itype(6'h23, 0, $urandom_range(0, 7), 16'(16'h800 + 4 * $urandom_range(0, 63))));
            4:    put(addr, itype(6'h2B, 0, $urandom_range(0, 7), 16'(16'h800 + 4 * $urandom_range(0, 63))));
            5:    put(addr, itype(6'h04, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom_range(0, 2))));
            6:    put(addr, {6'h02, 26'((addr + 32'd4 + 32'(4 * $urandom_range(0, 1))) >> 2)});
            default: put(addr, itype(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom)));
         endcase
      end
      for (int p = len; p < len + 3; p++) put(32'h40 + 32'(4 * p), 32'hFC00_0000);
   endtask

   initial begin
      int n;
      reset = 1'b0;
      mem_ready = 1'b0;

      load_directed();
      model_run(mcyc, mpc);
      do_reset();
      run_prog(0, mcyc, mpc, dcyc, dwait);
      chk("dir_cycles", dcyc, 32'd45);
      chk("dir_sw_add", mem[2], 32'd2);
      chk("dir_lw_copy", mem[3], 32'd2);
      chk("dir_slt", mem[4], 32'd1);
      chk("dir_after_jump", mem[8], 32'd2);

      load_directed();
      model_run(mcyc, mpc);
      do_reset();
      run_prog(2, mcyc, mpc, dcyc, dwait);
      chk("stall_waits", dwait, 32'd12);

      clear_mem();
      put(32'h40, itype(6'h08, 0, 1, 16'd7));
      put(32'h44, itype(6'h2B, 0, 1, 16'h30));
      put(32'h48, 32'hFC00_0000);
      do_reset();
      n = 0;
      while (!(mem_req && mem_we) && n < 50) begin
         mem_ready = 1'b1;
         @(negedge clk);
         n++;
      end
      chk("reach_write", {31'd0, mem_we}, 32'd1);
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("wait_addr", mem_addr, 32'h30);
      chk("wait_wdata", mem_wdata, 32'd7);
      #2 reset = 1'b0;
      #1;
      chk("async_req_drop", {31'd0, mem_req}, 32'd0);
      chk("async_state", {28'd0, state_out}, 32'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      chk("write_abandoned", mem[12], 32'd0);

      for (int r = 0; r < 4; r++) begin
         load_random(30);
         model_run(mcyc, mpc);
         do_reset();
         run_prog(r == 3 ? 2 : 1, mcyc, mpc, dcyc, dwait);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
